ins_loader: RTL and testbench
=============================

# ins_loader

Boot-time program loader that writes the instruction memory. It accepts a framed byte stream over a valid/ready handshake and checks a header and an XOR checksum. It drives a byte-wide write port into the byte-addressed instruction store and holds the CPU until a good image is in place. It sits between the host link (UART/debug receiver) and the write side of the instruction memory; the fetch side reads the same storage big-endian (lowest address = instruction bits 31:24).

## Interface
- MEM_BYTES, 128, instruction store size in bytes; must be a multiple of 4; max word count = MEM_BYTES/4.
- ADDR_W, 8, width of the byte address.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  single-cycle request to (re)enter loading.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction-memory byte write strobe.
- wr_addr  out  ADDR_W  byte address for the write.
- wr_data  out  8  byte to write.
- cpu_hold  out  1  1 = CPU held (fetch must not run).
- load_done  out  1  valid image loaded.
- load_err  out  1  frame rejected.

## Operation
- Frame format: 0xA5 sync, then length byte N (instruction words), then 4N payload bytes in memory order (byte k goes to address k, starting at 0), then a checksum byte equal to the XOR of all 4N payload bytes.
- A byte is accepted on a rising edge where byte_valid && byte_ready.
- States: IDLE, SYNC, LEN, DATA, CSUM, DONE, ERR. byte_ready = 1 exactly in SYNC, LEN, DATA and CSUM.
- IDLE: entered on reset; moves unconditionally to SYNC on the first edge after rst deasserts.
- SYNC: an accepted byte other than 0xA5 is discarded. An accepted 0xA5 moves to LEN.
- LEN: on an accepted byte, N = 0 or N > MEM_BYTES/4 moves to ERR. Otherwise the loader latches N, clears the address counter and the running checksum, and moves to DATA.
- DATA: each accepted byte is written to the current address, XORed into the checksum, and the address increments. The accepted byte with address 4N-1 moves to CSUM. The address never wraps; it never exceeds MEM_BYTES-1.
- CSUM: an accepted byte equal to the running checksum moves to DONE; any other value moves to ERR.
- DONE: load_done = 1, cpu_hold = 0. start moves to SYNC.
- ERR: load_err = 1, cpu_hold = 1. start moves to SYNC.
- start in SYNC, LEN, DATA or CSUM aborts to SYNC. Bytes already written stay in memory.
- start together with an accepted byte: start wins. The byte is consumed and dropped, and no write occurs.
- Entering SYNC by any path sets cpu_hold = 1 and clears load_done and load_err.
- Memory contents are never cleared by this block.

## Timing
- Reset values, applied asynchronously while rst = 0: byte_ready 0, wr_en 0, wr_addr 0, wr_data 0, cpu_hold 1, load_done 0, load_err 0, state IDLE.
- Reset mid-frame: outputs go to their reset values immediately; the partial frame is lost.
- wr_en, wr_addr and wr_data are registered. wr_en is a one-cycle pulse in the cycle after the accepting edge, carrying that byte's address and data. wr_addr and wr_data hold their values when wr_en = 0.
- Back-to-back accepted bytes produce back-to-back wr_en cycles; the sustained rate is one byte per clock.
- load_done, load_err and cpu_hold are registered and change on the same edge that accepts the CSUM byte, the LEN byte, or start.
- The final payload write (wr_en for address 4N-1) occurs in the cycle after its accepting edge, no later than the edge that accepts the checksum byte. Memory is therefore complete before cpu_hold falls.
- byte_valid gaps are allowed at any point and do not change state.

## Test plan
- Good frame A5 01 12 34 56 78 08: wr_en pulses at addresses 0..3 with data 12,34,56,78. On the edge accepting 08, load_done = 1 and cpu_hold = 0; the fetch side reads 0x12345678 at address 0.
- Leading garbage 00 FF A4, then the frame above: the first three bytes produce no wr_en. Result is identical to the good-frame case.
- Length 00 → load_err = 1, cpu_hold = 1, no writes. After start, length 0x21 (33, with MEM_BYTES = 128) → load_err = 1.
- Frame A5 01 12 34 56 78 09 (bad checksum): four writes occur, then load_err = 1 and cpu_hold stays 1. start clears load_err and returns to SYNC.
- Maximum frame N = 0x20 with byte_valid toggling randomly: 128 writes at addresses 0..127, no wrap, then load_done = 1 after the correct checksum.
- Two special cases, then recovery:
  - rst pulsed low after 2 DATA bytes: outputs reach reset values asynchronously.
  - start asserted in DATA with byte_valid = 1: no write for that byte, state goes to SYNC.
  - In both cases a following good frame loads correctly.

Source files
------------

// File: rtl/ins_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : ins_loader_if
// Purpose  : Byte-stream handshake plus instruction-memory write port of the loader.
// Revision : 1.0
// ============================================================================
interface ins_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err
    );

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err
    );
endinterface
`default_nettype wire

// File: rtl/ins_loader.sv
`default_nettype none
// ============================================================================
// Module   : ins_loader
// Purpose  : Framed boot loader (sync, length, payload, XOR checksum) into instruction memory.
// Revision : 1.0
// ============================================================================
module ins_loader #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    ins_loader_if.slave  bus
);
    localparam int         c_MAX_WORDS = MEM_BYTES / 4;
    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last;
    logic [7:0]        r_csum;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_hold;
    logic              r_done;
    logic              r_err;
    logic              w_ready;
    logic              w_take;
    logic              w_wr;
    logic              w_len_ok;

    assign w_ready  = (r_state == S_SYNC) || (r_state == S_LEN) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);
    // start beats a simultaneously offered byte: the byte is consumed but dropped
    assign w_take   = bus.byte_valid && w_ready && !bus.start;
    assign w_len_ok = (bus.byte_data != 8'd0) && (32'(bus.byte_data) <= c_MAX_WORDS);

    always_comb begin
        w_next = r_state;
        w_wr   = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_SYNC;
            S_SYNC: begin
                if (bus.start)
                    w_next = S_SYNC;
                else if (w_take && bus.byte_data == c_SYNC_BYTE)
                    w_next = S_LEN;
            end
            S_LEN: begin
                if (bus.start)
                    w_next = S_SYNC;
                else if (w_take)
                    w_next = w_len_ok ? S_DATA : S_ERR;
            end
            S_DATA: begin
                if (bus.start) begin
                    w_next = S_SYNC;
                end else if (w_take) begin
                    w_wr = 1'b1;
                    if (r_addr == r_last)
                        w_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (bus.start)
                    w_next = S_SYNC;
                else if (w_take)
                    w_next = (bus.byte_data == r_csum) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (bus.start)
                    w_next = S_SYNC;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_last    <= '0;
            r_csum    <= 8'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'd0;
            r_hold    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hold  <= (w_next != S_DONE);
            r_done  <= (w_next == S_DONE);
            r_err   <= (w_next == S_ERR);
            r_wr_en <= w_wr;
            if (r_state == S_LEN && w_take && w_len_ok) begin
                // last payload address is 4N-1
                r_last <= ADDR_W'({bus.byte_data, 2'b00} - 10'd1);
                r_addr <= '0;
                r_csum <= 8'd0;
            end
            if (w_wr) begin
                r_wr_addr <= r_addr;
                r_wr_data <= bus.byte_data;
                r_csum    <= r_csum ^ bus.byte_data;
                if (r_addr != r_last)
                    r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.cpu_hold   = r_hold;
    assign bus.load_done  = r_done;
    assign bus.load_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_ins_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_loader
// Purpose  : Self-checking bench for ins_loader: frame table plus reset/abort sequences.
// Revision : 1.0
// ============================================================================
module tb_ins_loader;
    localparam int c_MEM_BYTES = 128;
    localparam int c_ADDR_W    = 8;

    logic clk;
    logic rst;

    ins_loader_if #(.ADDR_W(c_ADDR_W)) bus ();

    ins_loader #(
        .MEM_BYTES(c_MEM_BYTES),
        .ADDR_W   (c_ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] len;
        bit         garbage;
        bit         bad_csum;
        bit         gaps;
        bit         fixed;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    wr_t        q[$];
    logic [7:0] mem [c_MEM_BYTES];
    logic [7:0] fix [4];
    vec_t       vecs[7];
    int         n_total = 0;
    int         n_bad   = 0;
    int         n_wr    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // write-port scoreboard and memory image
    always @(negedge clk) begin
        if (rst && bus.wr_en) begin
            n_wr++;
            mem[bus.wr_addr] = bus.wr_data;
            if (q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL wr_unexpected: got addr %h data %h want no write", bus.wr_addr, bus.wr_data);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr_data", {16'd0, bus.wr_addr, bus.wr_data}, {16'd0, e.a, e.d});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.byte_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        t = 0;
        while (!bus.byte_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.byte_ready) begin
            n_total++;
            n_bad++;
            $display("FAIL ready_timeout: got byte_ready 0 want 1 for byte %h", b);
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("start_hold",  {31'd0, bus.cpu_hold},   32'd1);
        chk("start_done",  {31'd0, bus.load_done},  32'd0);
        chk("start_err",   {31'd0, bus.load_err},   32'd0);
        chk("start_ready", {31'd0, bus.byte_ready}, 32'd1);
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0] cs;
        logic [7:0] b;
        bit         len_ok;
        int         nb;
        n_wr   = 0;
        cs     = 8'd0;
        len_ok = (v.len != 8'd0) && (int'(v.len) <= c_MEM_BYTES / 4);
        nb     = len_ok ? 4 * int'(v.len) : 0;
        if (v.garbage) begin
            send(8'h00, 1'b0);
            send(8'hFF, 1'b0);
            send(8'hA4, 1'b0);
        end
        send(8'hA5, v.gaps);
        send(v.len, v.gaps);
        for (int i = 0; i < nb; i++) begin
            b = v.fixed ? fix[i % 4] : 8'($urandom);
            q.push_back({8'(i), b});
            cs = cs ^ b;
            send(b, v.gaps);
        end
        if (len_ok)
            send(v.bad_csum ? (cs ^ 8'h01) : cs, v.gaps);
        chk("frame_done",  {31'd0, bus.load_done},  {31'd0, v.exp_done});
        chk("frame_err",   {31'd0, bus.load_err},   {31'd0, v.exp_err});
        chk("frame_hold",  {31'd0, bus.cpu_hold},   {31'd0, !v.exp_done});
        chk("frame_ready", {31'd0, bus.byte_ready}, 32'd0);
        @(posedge clk); #1;
        chk("frame_nwr",   32'(n_wr),     32'(nb));
        chk("frame_qempty", 32'(q.size()), 32'd0);
        if (v.fixed && len_ok)
            chk("fetch_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h12345678);
    endtask

    initial begin
        fix[0] = 8'h12; fix[1] = 8'h34; fix[2] = 8'h56; fix[3] = 8'h78;
        //         len    garb  badcs gaps  fixed done  err
        vecs[0] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < c_MEM_BYTES; i++) mem[i] = 8'h00;

        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #23;
        chk("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.wr_en},      32'd0);
        chk("rst_waddr", {24'd0, bus.wr_addr},    32'd0);
        chk("rst_wdata", {24'd0, bus.wr_data},    32'd0);
        chk("rst_hold",  {31'd0, bus.cpu_hold},   32'd1);
        chk("rst_done",  {31'd0, bus.load_done},  32'd0);
        chk("rst_err",   {31'd0, bus.load_err},   32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, bus.byte_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            pulse_start();
            run_frame(vecs[i]);
        end

        // reset in the middle of the payload
        pulse_start();
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        q.push_back({8'h00, 8'hC3}); send(8'hC3, 1'b0);
        q.push_back({8'h01, 8'h3C}); send(8'h3C, 1'b0);
        #6;
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, bus.byte_ready}, 32'd0);
        chk("midrst_wr_en", {31'd0, bus.wr_en},      32'd0);
        chk("midrst_waddr", {24'd0, bus.wr_addr},    32'd0);
        chk("midrst_wdata", {24'd0, bus.wr_data},    32'd0);
        chk("midrst_hold",  {31'd0, bus.cpu_hold},   32'd1);
        chk("midrst_done",  {31'd0, bus.load_done},  32'd0);
        chk("midrst_err",   {31'd0, bus.load_err},   32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_qempty", 32'(q.size()), 32'd0);
        run_frame(vecs[0]);

        // start collides with an offered payload byte
        pulse_start();
        n_wr = 0;
        send(8'hA5, 1'b0);
        send(8'h01, 1'b0);
        q.push_back({8'h00, 8'h12}); send(8'h12, 1'b0);
        q.push_back({8'h01, 8'h34}); send(8'h34, 1'b0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h99;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        chk("abort_wr_en", {31'd0, bus.wr_en},      32'd0);
        chk("abort_ready", {31'd0, bus.byte_ready}, 32'd1);
        chk("abort_hold",  {31'd0, bus.cpu_hold},   32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_nwr", 32'(n_wr), 32'd2);
        run_frame(vecs[0]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
